// File: rtl/cond_pkg.sv
// Shared types for condition-code evaluation and branch resolution.
// Imported by cond_eval and cond_flag_unit.
package cond_pkg;

  // ARM condition codes, encoded exactly as they appear in the instruction
  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  // Branch flavours resolved by the flag unit
  typedef enum logic [1:0] {
    BK_COND = 2'd0,
    BK_CBZ  = 2'd1,
    BK_CBNZ = 2'd2,
    BK_B    = 2'd3
  } br_kind_e;

  // Architectural flags, packed so the vector form reads {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code evaluator: given a set of NZCV flags and
// a condition code, reports whether the condition holds. Kept separate so a
// conditional-select unit can reuse the same decoder.
module cond_eval
  import cond_pkg::*;
(
  input  nzcv_t i_flags,
  input  cond_e i_cond,
  output logic  o_holds
);

  // Signed compares collapse to whether N and V agree
  logic w_nEqV;

  assign w_nEqV = (i_flags.n == i_flags.v);

  // Decode every condition directly; NV behaves like AL on ARMv8
  always_comb begin
    o_holds = 1'b0;
    unique case (i_cond)
      EQ: o_holds = i_flags.z;
      NE: o_holds = !i_flags.z;
      CS: o_holds = i_flags.c;
      CC: o_holds = !i_flags.c;
      MI: o_holds = i_flags.n;
      PL: o_holds = !i_flags.n;
      VS: o_holds = i_flags.v;
      VC: o_holds = !i_flags.v;
      HI: o_holds = i_flags.c && !i_flags.z;
      LS: o_holds = !i_flags.c || i_flags.z;
      GE: o_holds = w_nEqV;
      LT: o_holds = !w_nEqV;
      GT: o_holds = !i_flags.z && w_nEqV;
      LE: o_holds = i_flags.z || !w_nEqV;
      AL: o_holds = 1'b1;
      NV: o_holds = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Consumer side of the ALU flag interface. Captures NZCV on flag-setting ops,
// resolves B.cond / CBZ / CBNZ / B and presents the decision through a
// one-entry valid/ready output register, counting taken decisions.
// Optional feature macro: FLAG_FORWARD_EN -- when defined, a B.cond issued in
// the same cycle as a flag-setting op sees the incoming ALU flags.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_cout,
  input  logic             alu_over,
  input  logic             set_flags,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_kind,
  input  logic [3:0]       br_cond,
  input  logic             br_reg_zero,
  output logic             take_valid,
  input  logic             take_ready,
  output logic             take_branch,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  nzcv_t            r_flags;
  logic             r_takeValid;
  logic             r_takeBranch;
  logic [CNT_W-1:0] r_takenCnt;

  nzcv_t            w_aluFlags;
  nzcv_t            w_evalFlags;
  br_kind_e         w_kind;
  logic             w_condHolds;
  logic             w_decision;
  logic             w_brReady;
  logic             w_accept;

  assign w_aluFlags = '{n: alu_neg, z: alu_zero, c: alu_cout, v: alu_over};
  assign w_kind     = br_kind_e'(br_kind);

`ifdef FLAG_FORWARD_EN
  assign w_evalFlags = set_flags ? w_aluFlags : r_flags;
`else
  assign w_evalFlags = r_flags;
`endif

  cond_eval u_condEval (
    .i_flags (w_evalFlags),
    .i_cond  (cond_e'(br_cond)),
    .o_holds (w_condHolds)
  );

  // A request can enter whenever the output slot is empty or being drained
  assign w_brReady = !r_takeValid || take_ready;
  assign w_accept  = br_valid && w_brReady;

  // Pick the taken/not-taken outcome for the branch kind presented this cycle
  always_comb begin
    w_decision = 1'b0;
    unique case (w_kind)
      BK_COND: w_decision = w_condHolds;
      BK_CBZ:  w_decision = br_reg_zero;
      BK_CBNZ: w_decision = !br_reg_zero;
      BK_B:    w_decision = 1'b1;
    endcase
  end

  // Architectural NZCV register, updated only by flag-setting ops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= nzcv_t'(RESET_FLAGS);
    end else if (set_flags) begin
      r_flags <= w_aluFlags;
    end
  end

  // One-entry decision register: load on accept, drain on take_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_takeValid  <= 1'b0;
      r_takeBranch <= 1'b0;
    end else if (w_accept) begin
      r_takeValid  <= 1'b1;
      r_takeBranch <= w_decision;
    end else if (take_ready) begin
      r_takeValid  <= 1'b0;
      r_takeBranch <= 1'b0;
    end
  end

  // Count accepted taken decisions, wrapping at the counter width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_takenCnt <= '0;
    end else if (w_accept && w_decision) begin
      r_takenCnt <= r_takenCnt + CNT_W'(1);
    end
  end

  assign br_ready    = w_brReady;
  assign take_valid  = r_takeValid;
  assign take_branch = r_takeBranch;
  assign flags_q     = r_flags;
  assign taken_cnt   = r_takenCnt;

endmodule
